ddr2_cmd_arbiter: RTL

//  Shares the single DDR2 controller command bus (cmd/sz/op/addr/din, fetching) among NREQ requesters.
//  - Round-robin arbitration; registered command issue; waits for controller acceptance.
//  - Sequences the data phase of block writes.
//  - Sits between the requester drivers and the DDR2 controller; its outputs are the bus the command monitor checks.

---
 rtl/ddr2_cmd_arbiter_pkg.sv | 39 +++
 rtl/ddr2_cmd_arbiter_rr_picker.sv | 29 ++
 rtl/ddr2_cmd_arbiter.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/ddr2_cmd_arbiter_pkg.sv
// Shared types and command-field helpers for the DDR2 command arbiter.
package ddr2_cmd_arbiter_pkg;

    typedef logic [1:0]  ulogic2;
    typedef logic [2:0]  ulogic3;
    typedef logic [15:0] ulogic16;
    typedef logic [24:0] ulogic25;

    typedef enum logic [2:0] {
        CMD_NOP    = 3'd0,
        CMD_SCR_RD = 3'd1,
        CMD_SCR_WR = 3'd2,
        CMD_BLK_RD = 3'd3,
        CMD_BLK_WR = 3'd4,
        CMD_ATM_RD = 3'd5,
        CMD_ATM_WR = 3'd6,
        CMD_NOP7   = 3'd7
    } cmd_e;

    typedef enum logic [1:0] {IDLE, ISSUE, BLKWR} arb_state_t;

    function automatic logic cmd_is_nop(input ulogic3 c);
        return (c == CMD_NOP) || (c == CMD_NOP7);
    endfunction

    // Block transfers have an implied size, so only scalar and atomic commands carry sz.
    function automatic logic cmd_uses_sz(input ulogic3 c);
        return (c == CMD_SCR_RD) || (c == CMD_SCR_WR) || (c == CMD_ATM_RD) || (c == CMD_ATM_WR);
    endfunction

    function automatic logic cmd_uses_op(input ulogic3 c);
        return (c == CMD_ATM_RD) || (c == CMD_ATM_WR);
    endfunction

    function automatic logic cmd_has_wdata(input ulogic3 c);
        return (c == CMD_SCR_WR) || (c == CMD_BLK_WR) || (c == CMD_ATM_WR);
    endfunction

endpackage

// File: rtl/ddr2_cmd_arbiter_rr_picker.sv
// Combinational round-robin priority encoder: first eligible index after i_ptr, with wrap.
module rr_picker #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         i_elig,
    input  logic [$clog2(NREQ)-1:0] i_ptr,
    output logic [$clog2(NREQ)-1:0] o_win,
    output logic                    o_any
);

    localparam int          GW = $clog2(NREQ);
    localparam int unsigned N  = NREQ;

    logic [31:0] w_idx;

    always_comb begin
        o_win = '0;
        o_any = 1'b0;
        w_idx = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            w_idx = (32'(i_ptr) + k) % N;
            if (!o_any && i_elig[w_idx[GW-1:0]]) begin
                o_any = 1'b1;
                o_win = w_idx[GW-1:0];
            end
        end
    end

endmodule

// File: rtl/ddr2_cmd_arbiter.sv
// Round-robin arbiter sharing the DDR2 controller command bus among NREQ requesters.
// Optional issue watchdog enabled by defining CMD_ARB_TIMEOUT_EN.
module ddr2_cmd_arbiter
    import ddr2_cmd_arbiter_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int BLK_BEATS = 8,
    parameter int TIMEOUT   = 1024
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ-1:0][2:0]     req_cmd,
    input  logic [NREQ-1:0][1:0]     req_sz,
    input  logic [NREQ-1:0][2:0]     req_op,
    input  logic [NREQ-1:0][24:0]    req_addr,
    input  logic [NREQ-1:0][15:0]    req_din,
    output logic [NREQ-1:0]          req_gnt,
    output logic [NREQ-1:0]          req_dack,
    input  logic                     fetching,
    output logic [2:0]               cmd,
    output logic [1:0]               sz,
    output logic [2:0]               op,
    output logic [24:0]              addr,
    output logic [15:0]              din,
    output logic                     busy,
    output logic [$clog2(NREQ)-1:0]  grant_id,
    output logic                     timeout_err
);

    localparam int GW = $clog2(NREQ);
    localparam int BW = (BLK_BEATS > 1) ? $clog2(BLK_BEATS) : 1;

    if (NREQ < 2 || NREQ > 8 || BLK_BEATS < 1 || TIMEOUT < 1) begin : g_param_check
        $error("ddr2_cmd_arbiter: parameter out of range");
    end

    arb_state_t      r_state, w_state_nxt;
    logic [GW-1:0]   r_rr_ptr, r_owner, w_win;
    logic [NREQ-1:0] w_elig, r_gnt;
    logic            w_any, w_accept, w_timeout, w_last_beat;
    logic [BW-1:0]   r_beat;
    ulogic3          r_cmd, r_op, w_wcmd;
    ulogic2          r_sz;
    ulogic25         r_addr;
    ulogic16         r_din;

    for (genvar g = 0; g < NREQ; g++) begin : g_elig
        assign w_elig[g] = req_valid[g] && !cmd_is_nop(req_cmd[g]);
    end

    rr_picker #(.NREQ(NREQ)) u_rr_picker (
        .i_elig (w_elig),
        .i_ptr  (r_rr_ptr),
        .o_win  (w_win),
        .o_any  (w_any)
    );

    assign w_wcmd      = req_cmd[w_win];
    assign w_accept    = (r_state == ISSUE) && fetching;
    assign w_last_beat = (r_beat == BW'(BLK_BEATS - 1));

`ifdef CMD_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] r_tcnt;
    logic          r_timeout_err;

    assign w_timeout = (r_state == ISSUE) && !fetching && (r_tcnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tcnt        <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (r_state == ISSUE && !fetching) r_tcnt <= w_timeout ? '0 : r_tcnt + 1'b1;
            else                               r_tcnt <= '0;
            if (w_timeout) r_timeout_err <= 1'b1;
        end
    end

    assign timeout_err = r_timeout_err;
`else
    assign w_timeout   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_any) w_state_nxt = ISSUE;
            ISSUE: begin
                if (w_accept)       w_state_nxt = (r_cmd == CMD_BLK_WR) ? BLKWR : IDLE;
                else if (w_timeout) w_state_nxt = IDLE;
            end
            BLKWR:   if (w_last_beat) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rr_ptr <= GW'(NREQ - 1);
            r_owner  <= '0;
            r_gnt    <= '0;
            r_beat   <= '0;
            r_cmd    <= CMD_NOP;
            r_sz     <= '0;
            r_op     <= '0;
            r_addr   <= '0;
            r_din    <= '0;
        end else begin
            r_gnt <= '0;
            case (r_state)
                IDLE: if (w_any) begin
                    r_owner <= w_win;
                    r_cmd   <= w_wcmd;
                    r_sz    <= cmd_uses_sz(w_wcmd)   ? req_sz[w_win]  : '0;
                    r_op    <= cmd_uses_op(w_wcmd)   ? req_op[w_win]  : '0;
                    r_addr  <= req_addr[w_win];
                    r_din   <= cmd_has_wdata(w_wcmd) ? req_din[w_win] : '0;
                end
                // Timeout also moves the pointer past the owner so a stuck request cannot starve others.
                ISSUE: if (w_accept || w_timeout) begin
                    if (w_accept) r_gnt[r_owner] <= 1'b1;
                    r_rr_ptr <= r_owner;
                    r_beat   <= '0;
                    r_cmd    <= CMD_NOP;
                    r_sz     <= '0;
                    r_op     <= '0;
                    r_addr   <= '0;
                    r_din    <= '0;
                end
                BLKWR:   r_beat <= w_last_beat ? '0 : r_beat + 1'b1;
                default: ;
            endcase
        end
    end

    // During block-write beats the data path bypasses the output registers so each beat lands in one cycle.
    assign cmd      = (r_state == BLKWR) ? 3'bxxx : r_cmd;
    assign din      = (r_state == BLKWR) ? req_din[r_owner] : r_din;
    assign req_dack = (r_state == BLKWR) ? (NREQ'(1) << r_owner) : '0;
    assign sz       = r_sz;
    assign op       = r_op;
    assign addr     = r_addr;
    assign req_gnt  = r_gnt;
    assign busy     = (r_state != IDLE);
    assign grant_id = r_owner;

endmodule
